// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: op-select encoding and select width.
package alu_pkg;

  localparam int ALU_SEL_W = 2;

  localparam logic [ALU_SEL_W-1:0] OP_AND = 2'd0;
  localparam logic [ALU_SEL_W-1:0] OP_OR  = 2'd1;
  localparam logic [ALU_SEL_W-1:0] OP_XOR = 2'd2;
  localparam logic [ALU_SEL_W-1:0] OP_ADD = 2'd3;

endpackage

// File: rtl/alu_ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full adders.
module alu_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/alu_core.sv
// Registered WIDTH-bit ALU: AND / OR / XOR / ADD-with-carry, one-cycle latency.
// Optional zero and signed-overflow flags are built when ALU_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ALU_SEL_W-1:0] alu_select,
  input  logic                 alu_carry_in,
  output logic [WIDTH-1:0]     alu_output,
  output logic                 alu_carry_out
`ifdef ALU_FLAGS_EN
  ,
  output logic                 alu_zero,
  output logic                 alu_overflow
`endif
);

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] res_next;
  logic             cout_next;

  alu_ripple_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (a),
    .b   (b),
    .cin (alu_carry_in),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Op select mux; an unknown select propagates X rather than picking an op.
  always_comb begin
    res_next  = 'x;
    cout_next = 1'bx;
    case (alu_select)
      OP_AND: begin
        res_next  = a & b;
        cout_next = 1'b0;
      end
      OP_OR: begin
        res_next  = a | b;
        cout_next = 1'b0;
      end
      OP_XOR: begin
        res_next  = a ^ b;
        cout_next = 1'b0;
      end
      OP_ADD: begin
        res_next  = add_sum;
        cout_next = add_cout;
      end
    endcase
  end

  // Output register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_output    <= '0;
      alu_carry_out <= 1'b0;
    end else begin
      alu_output    <= res_next;
      alu_carry_out <= cout_next;
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_next;
  logic ovf_next;

  assign zero_next = (res_next == '0);
  // Signed overflow: operands agree in sign but the sum's sign differs.
  assign ovf_next  = (alu_select == OP_ADD) && (a[WIDTH-1] == b[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != a[WIDTH-1]);

  // Flag registers share the result's latency and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_zero     <= 1'b0;
      alu_overflow <= 1'b0;
    end else begin
      alu_zero     <= zero_next;
      alu_overflow <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed literal checks plus randomized stimulus
// compared every cycle against an arithmetic reference model.
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_alu_core;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   sel;
  logic         cin;
  logic [W-1:0] alu_output;
  logic         alu_carry_out;
`ifdef ALU_FLAGS_EN
  logic         alu_zero;
  logic         alu_overflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] e_out;
  logic         e_cout;
  logic         e_zero;
  logic         e_ovf;
  logic         model_ok = 1'b0;
  int           s_u;
  int           s_s;
  int           a_s;
  int           b_s;

  alu_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .alu_select   (sel),
    .alu_carry_in (cin),
    .alu_output   (alu_output),
    .alu_carry_out(alu_carry_out)
`ifdef ALU_FLAGS_EN
    ,
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result of the inputs present at each rising edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      e_out    = '0;
      e_cout   = 1'b0;
      e_zero   = 1'b0;
      e_ovf    = 1'b0;
      model_ok = 1'b1;
    end else begin
      e_cout = 1'b0;
      e_ovf  = 1'b0;
      case (sel)
        2'd0: e_out = a & b;
        2'd1: e_out = a | b;
        2'd2: e_out = a ^ b;
        default: begin
          s_u    = int'(a) + int'(b) + int'(cin);
          e_out  = W'(s_u % MOD);
          e_cout = (s_u >= MOD);
          a_s    = (int'(a) >= HALF) ? int'(a) - MOD : int'(a);
          b_s    = (int'(b) >= HALF) ? int'(b) - MOD : int'(b);
          s_s    = a_s + b_s + int'(cin);
          e_ovf  = (s_s > HALF - 1) || (s_s < -HALF);
        end
      endcase
      e_zero = (e_out == '0);
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (model_ok) begin
      check("out", 32'(alu_output), 32'(e_out));
      check("cout", 32'(alu_carry_out), 32'(e_cout));
`ifdef ALU_FLAGS_EN
      check("zero", 32'(alu_zero), 32'(e_zero));
      check("ovf", 32'(alu_overflow), 32'(e_ovf));
`endif
    end
  end

  task automatic apply(input logic r, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [1:0] s, input logic c);
    @(negedge clk);
    rst = r;
    a   = aa;
    b   = bb;
    sel = s;
    cin = c;
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] o, input logic co,
                            input logic z, input logic ov);
    @(posedge clk);
    #1;
    check({name, "_out"}, 32'(alu_output), 32'(o));
    check({name, "_cout"}, 32'(alu_carry_out), 32'(co));
`ifdef ALU_FLAGS_EN
    check({name, "_zero"}, 32'(alu_zero), 32'(z));
    check({name, "_ovf"}, 32'(alu_overflow), 32'(ov));
`endif
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; sel = '0; cin = 1'b0;

    apply(1'b1, 4'h5, 4'h3, 2'd3, 1'b1);
    apply(1'b1, 4'h5, 4'h3, 2'd3, 1'b1);
    expect_lit("reset", 4'h0, 1'b0, 1'b0, 1'b0);

    apply(1'b0, 4'h1, 4'hE, 2'd2, 1'b0);
    expect_lit("xor_1_e", 4'hF, 1'b0, 1'b0, 1'b0);

    apply(1'b0, 4'hE, 4'h1, 2'd3, 1'b1);
    expect_lit("add_e_1_c", 4'h0, 1'b1, 1'b1, 1'b0);

    apply(1'b0, 4'hF, 4'hF, 2'd0, 1'b1);
    expect_lit("and_f_f", 4'hF, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'hF, 4'hF, 2'd2, 1'b1);
    expect_lit("xor_f_f", 4'h0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 4'h0, 4'h0, 2'd1, 1'b0);
    expect_lit("or_0_0", 4'h0, 1'b0, 1'b1, 1'b0);

    apply(1'b0, 4'h7, 4'h1, 2'd3, 1'b0);
    expect_lit("add_7_1", 4'h8, 1'b0, 1'b0, 1'b1);

    apply(1'b0, 4'hF, 4'hF, 2'd3, 1'b1);
    expect_lit("add_f_f_c", 4'hF, 1'b1, 1'b0, 1'b0);

    apply(1'b0, 4'h8, 4'h8, 2'd3, 1'b0);
    expect_lit("add_8_8", 4'h0, 1'b1, 1'b1, 1'b1);

    apply(1'b0, 4'hA, 4'h6, 2'd1, 1'b1);
    expect_lit("or_a_6", 4'hE, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with reset asserted mid-stream.
    apply(1'b0, 4'h3, 4'h4, 2'd3, 1'b0);
    expect_lit("b2b_add", 4'h7, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'h3, 4'h4, 2'd3, 1'b1);
    expect_lit("b2b_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'h5, 4'h5, 2'd3, 1'b1);
    expect_lit("b2b_resume", 4'hB, 1'b0, 1'b0, 1'b1);

    // Randomized back-to-back ops with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 15) == 0), W'($urandom_range(0, MOD - 1)),
            W'($urandom_range(0, MOD - 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
